// File: rtl/mul_pkg.sv
// Shared definitions for the N x M multiplier datapath and its operand loader.
//   - state_t : loader FSM encoding (LOAD = 1'b0, ISSUE = 1'b1)
//   - N_DEF, M_DEF, CW_DEF : default operand / counter widths, shared with the multiplier
//   - ADDR_A, ADDR_B : operand select codes carried on addr
package mul_pkg;

    typedef enum logic {
        LOAD  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam int N_DEF  = 8;
    localparam int M_DEF  = 8;
    localparam int CW_DEF = 4;

    localparam logic ADDR_A = 1'b0;
    localparam logic ADDR_B = 1'b1;

endpackage

// File: rtl/mul_operand_loader_if.sv
// Bus between the serial operand source / multiplier and mul_operand_loader.
// Ports (all signals inside the interface):
//   addr, D, shift_en : serial load of one bit into operand A (addr=0) or B (addr=1)
//   clr               : synchronous clear of operands, counters and error flags
//   load_go           : request to issue the assembled operands
//   op_ready          : multiplier accepts operands
//   a_out, b_out      : operands presented in parallel
//   op_valid          : a_out/b_out complete and stable
//   a_full, b_full    : operand A / B holds all of its bits
//   err_ovf, err_go   : sticky error flags
// Modports: master = stimulus / multiplier side, slave = loader.
interface mul_operand_loader_if #(
    parameter int N = 8,
    parameter int M = 8
);
    logic         addr;
    logic         D;
    logic         shift_en;
    logic         clr;
    logic         load_go;
    logic         op_ready;
    logic [N-1:0] a_out;
    logic [M-1:0] b_out;
    logic         op_valid;
    logic         a_full;
    logic         b_full;
    logic         err_ovf;
    logic         err_go;

    modport master (
        output addr, D, shift_en, clr, load_go, op_ready,
        input  a_out, b_out, op_valid, a_full, b_full, err_ovf, err_go
    );

    modport slave (
        input  addr, D, shift_en, clr, load_go, op_ready,
        output a_out, b_out, op_valid, a_full, b_full, err_ovf, err_go
    );
endinterface

// File: rtl/serial_operand_reg.sv
// MSB-first serial-in / parallel-out operand register with a bit counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of register and counter (priority over shift)
//   shift      : qualified shift request for this cycle
//   d          : serial data bit
//   q          : assembled operand
//   full       : counter has reached W
//   ovf        : combinational pulse, shift requested while already full
module serial_operand_reg #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         shift,
    input  logic         d,
    output logic [W-1:0] q,
    output logic         full,
    output logic         ovf
);
    localparam logic [CW-1:0] LIMIT = CW'(W);

    logic [CW-1:0] cnt;

    assign full = (cnt == LIMIT);
    // A shift into a full register is dropped; the caller turns this into a sticky flag.
    assign ovf  = shift && full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            cnt <= '0;
        end else if (clr) begin
            q   <= '0;
            cnt <= '0;
        end else if (shift && !full) begin
            q   <= {q[W-2:0], d};
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/mul_operand_loader.sv
// Upstream stage of the N x M multiplier: assembles operands A and B from a
// 1-bit serial stream and issues them in parallel with a valid/ready handshake.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mul_operand_loader_if.slave (serial load, control, operands, flags)
module mul_operand_loader
    import mul_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int M  = M_DEF,
    parameter int CW = CW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mul_operand_loader_if.slave  bus
);
    state_t       state;
    logic         op_valid;
    logic         err_ovf;
    logic         err_go;

    logic [N-1:0] a_q;
    logic [M-1:0] b_q;
    logic         a_full;
    logic         b_full;
    logic         a_ovf;
    logic         b_ovf;

    logic         in_load;
    logic         handshake;
    logic         reg_clr;
    logic         shift_a;
    logic         shift_b;

    assign in_load   = (state == LOAD);
    assign handshake = (state == ISSUE) && bus.op_ready;
    // Operands are consumed on the handshake, so they are wiped together with clr.
    assign reg_clr   = bus.clr || handshake;
    // Shifts only count in LOAD; in ISSUE the operands must stay frozen.
    assign shift_a   = in_load && bus.shift_en && (bus.addr == ADDR_A);
    assign shift_b   = in_load && bus.shift_en && (bus.addr == ADDR_B);

    serial_operand_reg #(.W(N), .CW(CW)) u_reg_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (reg_clr),
        .shift (shift_a),
        .d     (bus.D),
        .q     (a_q),
        .full  (a_full),
        .ovf   (a_ovf)
    );

    serial_operand_reg #(.W(M), .CW(CW)) u_reg_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (reg_clr),
        .shift (shift_b),
        .d     (bus.D),
        .q     (b_q),
        .full  (b_full),
        .ovf   (b_ovf)
    );

    // load_go looks at the full flags before this cycle's shift lands, so an
    // operand completed in the same cycle cannot be issued until the next go.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOAD;
            op_valid <= 1'b0;
            err_ovf  <= 1'b0;
            err_go   <= 1'b0;
        end else if (bus.clr) begin
            state    <= LOAD;
            op_valid <= 1'b0;
            err_ovf  <= 1'b0;
            err_go   <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (a_ovf || b_ovf) begin
                        err_ovf <= 1'b1;
                    end
                    if (bus.load_go) begin
                        if (a_full && b_full) begin
                            state    <= ISSUE;
                            op_valid <= 1'b1;
                        end else begin
                            err_go <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.op_ready) begin
                        state    <= LOAD;
                        op_valid <= 1'b0;
                    end
                end
                default: begin
                    state    <= LOAD;
                    op_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a_out    = a_q;
    assign bus.b_out    = b_q;
    assign bus.op_valid = op_valid;
    assign bus.a_full   = a_full;
    assign bus.b_full   = b_full;
    assign bus.err_ovf  = err_ovf;
    assign bus.err_go   = err_go;
endmodule
